// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: drives PC load/k from control-flow ops, with a return stack and post-transfer flush.
// Optional macro PC_SEQ_TRAP_EN: stack faults trap to TRAP_VEC and halt.
module pc_sequencer #(
  parameter int          DEPTH     = 4,
  parameter int          SPW       = 3,
  parameter logic [7:0]  RESET_VEC = 8'h00,
  parameter int          FLUSH_CYC = 1,
  parameter logic [7:0]  TRAP_VEC  = 8'hF0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     pc_cur,
  input  logic [2:0]     op,
  input  logic           op_valid,
  input  logic [7:0]     target,
  input  logic           zero,
  input  logic           stall,
  output logic           load,
  output logic [7:0]     k,
  output logic           flush,
  output logic [SPW-1:0] sp,
  output logic           stk_full,
  output logic           stk_empty,
  output logic           fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t         state_reg;
  logic [1:0]     flush_cnt_reg;
  logic [SPW-1:0] sp_reg;
  logic           fault_reg;
  logic           halt_pend_reg;
  logic [7:0]     stack_mem [DEPTH];

  logic          active, br_taken, push, pop, stk_fault, trap_hit, xfer;
  logic [AW-1:0] wr_idx, top_idx;

  assign stk_full  = (sp_reg == SPW'(DEPTH));
  assign stk_empty = (sp_reg == '0);
  assign sp        = sp_reg;
  assign fault     = fault_reg;
  assign flush     = (state_reg != RUN);
  assign wr_idx    = AW'(sp_reg);
  assign top_idx   = AW'(sp_reg - 1'b1);

  // Ops are only honoured in RUN on an unstalled cycle.
  assign active    = !reset && (state_reg == RUN) && !stall && op_valid;
  assign br_taken  = active && ((op == 3'd1) || (op == 3'd2 && zero) || (op == 3'd3 && !zero));
  assign push      = active && (op == 3'd4) && !stk_full;
  assign pop       = active && (op == 3'd5) && !stk_empty;
  assign stk_fault = active && (((op == 3'd4) && stk_full) || ((op == 3'd5) && stk_empty));

`ifdef PC_SEQ_TRAP_EN
  assign trap_hit = stk_fault;
`else
  assign trap_hit = 1'b0;
`endif

  assign xfer = br_taken || push || pop || trap_hit;

  always_comb begin
    load = 1'b0;
    k    = pc_cur;
    if (reset) begin
      load = 1'b1;
      k    = RESET_VEC;
    end else if (state_reg == HALT || stall) begin
      load = 1'b1;
      k    = pc_cur;
    end else if (pop) begin
      load = 1'b1;
      k    = stack_mem[top_idx];
    end else if (br_taken || push) begin
      load = 1'b1;
      k    = target;
    end else if (trap_hit) begin
      load = 1'b1;
      k    = TRAP_VEC;
    end
  end

  // Stack contents need no reset: sp=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_cur + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RUN;
      flush_cnt_reg <= 2'd0;
      sp_reg        <= '0;
      fault_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
    end else begin
      if (push)      sp_reg <= sp_reg + 1'b1;
      else if (pop)  sp_reg <= sp_reg - 1'b1;
      if (stk_fault) fault_reg <= 1'b1;

      case (state_reg)
        RUN: begin
          if (xfer && FLUSH_CYC > 0) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= 2'(FLUSH_CYC);
            halt_pend_reg <= trap_hit;
          end else if (trap_hit) begin
            state_reg <= HALT;
          end
        end
        FLUSH: begin
          if (!stall) begin
            flush_cnt_reg <= flush_cnt_reg - 2'd1;
            if (flush_cnt_reg == 2'd1) begin
              state_reg     <= halt_pend_reg ? HALT : RUN;
              halt_pend_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int         DEPTH     = 4;
  localparam int         SPW       = 3;
  localparam logic [7:0] RESET_VEC = 8'h00;
  localparam int         FLUSH_CYC = 1;
  localparam logic [7:0] TRAP_VEC  = 8'hF0;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     pc_cur = 8'h00;
  logic [2:0]     op = 3'd0;
  logic           op_valid = 1'b0;
  logic [7:0]     target = 8'h00;
  logic           zero = 1'b0;
  logic           stall = 1'b0;
  logic           load, flush, stk_full, stk_empty, fault;
  logic [7:0]     k;
  logic [SPW-1:0] sp;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state: PC, return stack as a queue, mode flags.
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_stk[$];
  logic       m_fault = 1'b0;
  int         m_flush = 0;
  logic       m_halt = 1'b0;
  logic       m_hpend = 1'b0;

  pc_sequencer #(
    .DEPTH(DEPTH), .SPW(SPW), .RESET_VEC(RESET_VEC),
    .FLUSH_CYC(FLUSH_CYC), .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .op(op), .op_valid(op_valid),
    .target(target), .zero(zero), .stall(stall), .load(load), .k(k),
    .flush(flush), .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t pc=%02h)", tag, got, exp, $time, m_pc);
    end
  endtask

  // Entered at a negedge; asserts reset, checks immediate effect, releases at a later negedge.
  task automatic do_reset(input int n);
    reset = 1'b1; op_valid = 1'b0; stall = 1'b0;
    #1;
    chk("rst_load", 32'(load), 32'd1);
    chk("rst_k", 32'(k), 32'(RESET_VEC));
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = RESET_VEC; m_stk.delete(); m_fault = 1'b0;
    m_flush = 0; m_halt = 1'b0; m_hpend = 1'b0;
    $display("[TB] reset %0d cycles", n);
  endtask

  // One cycle: drive at negedge, check outputs, advance model at posedge, return at negedge.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] t,
                      input logic z, input logic s);
    logic       e_load, e_flush, taken, trap, n_push, n_pop;
    logic [7:0] e_k, ret_addr;
    op_valid = v; op = o; target = t; zero = z; stall = s; pc_cur = m_pc;
    e_load = 1'b0; e_k = 8'h00; e_flush = 1'b0; taken = 1'b0; trap = 1'b0;
    n_push = 1'b0; n_pop = 1'b0;
    ret_addr = m_pc + 8'd1;
    if (m_halt) begin
      e_load = 1'b1; e_k = m_pc; e_flush = 1'b1;
    end else if (s) begin
      e_load = 1'b1; e_k = m_pc; e_flush = (m_flush > 0);
    end else if (m_flush > 0) begin
      e_flush = 1'b1;
    end else if (v) begin
      case (o)
        3'd1: taken = 1'b1;
        3'd2: taken = z;
        3'd3: taken = !z;
        3'd4: if (m_stk.size() < DEPTH) begin taken = 1'b1; n_push = 1'b1; end else trap = 1'b1;
        3'd5: if (m_stk.size() > 0) begin taken = 1'b1; n_pop = 1'b1; end else trap = 1'b1;
        default: ;
      endcase
      if (taken) begin
        e_load = 1'b1;
        e_k = n_pop ? m_stk[$] : t;
      end
`ifdef PC_SEQ_TRAP_EN
      if (trap) begin e_load = 1'b1; e_k = TRAP_VEC; end
`endif
    end
    #2;
    chk("load", 32'(load), 32'(e_load));
    if (e_load) chk("k", 32'(k), 32'(e_k));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("sp", 32'(sp), 32'(m_stk.size()));
    chk("stk_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
    chk("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
    chk("fault", 32'(fault), 32'(m_fault));
    $display("[TB] pc=%02h v=%0d op=%0d t=%02h z=%0d s=%0d -> load=%0d k=%02h flush=%0d sp=%0d fault=%0d",
             m_pc, v, o, t, z, s, load, k, flush, sp, fault);
    @(posedge clk);
    if (!m_halt && !s) begin
      if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0 && m_hpend) begin m_halt = 1'b1; m_hpend = 1'b0; end
      end else begin
        if (n_push) m_stk.push_back(ret_addr);
        if (n_pop) void'(m_stk.pop_back());
        if (trap) begin
          m_fault = 1'b1;
`ifdef PC_SEQ_TRAP_EN
          if (FLUSH_CYC == 0) m_halt = 1'b1; else begin m_hpend = 1'b1; m_flush = FLUSH_CYC; end
`endif
        end
        if (taken) m_flush = FLUSH_CYC;
      end
    end
    m_pc = e_load ? e_k : m_pc + 8'd1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    // Free-running increment after reset
    repeat (3) step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // JMP then op ignored during flush
    step(1'b1, 3'd1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // JZ not taken, JNZ taken
    step(1'b1, 3'd2, 8'h20, 1'b0, 1'b0);
    step(1'b1, 3'd3, 8'h20, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // Nested call/return
    step(1'b1, 3'd1, 8'h05, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'h30, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'h50, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // Underflow, then stall with pending JMP, then overflow
    step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h99, 1'b0, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 3'd4, 8'(8'h60 + 8'(i)), 1'b0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    end
    // Reset asserted during FLUSH
    step(1'b1, 3'd1, 8'hA0, 1'b0, 1'b0);
    do_reset(1);
    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset(int'($urandom_range(1, 3)));
      else step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom), $urandom_range(0, 99) < 15);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
